// File: rtl/ram_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_load_pkg
// Description : Shared types and constants for the RAM port-B load arbiter:
//               arbiter state encoding, bytes per RAM word, byte-lane index
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_load_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

endpackage : ram_load_pkg
`default_nettype wire

// File: rtl/ram_load_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_load_arbiter_if
// Description : Bundle of CPU request, loader byte stream, RAM port-B and
//               load status signals around the arbiter. The slave side is
//               the arbiter; the master side is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_load_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              prog_en;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              loading;
    logic [ADDR_W:0]   word_count;
    logic              frag_err;

    modport master (
        output prog_en, cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_valid, ld_byte,
        input  cpu_gnt, ld_ready, mem_addr, mem_we, mem_wdata, loading,
               word_count, frag_err
    );

    modport slave (
        input  prog_en, cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_valid, ld_byte,
        output cpu_gnt, ld_ready, mem_addr, mem_we, mem_wdata, loading,
               word_count, frag_err
    );

endinterface : ram_load_arbiter_if
`default_nettype wire

// File: rtl/ram_load_arbiter_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Assembles a little-endian byte stream into RAM words. Each
//               accepted byte lands in lane [byte index]; the index wraps
//               after the last lane and a word-complete pulse accompanies the
//               final byte.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import ram_load_pkg::*;
(
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        i_clear,
    input  wire logic                        i_accept,
    input  wire logic [7:0]                  i_byte,
    output logic [BYTES_PER_WORD*8-1:0]      o_word,
    output logic [LANE_W-1:0]                o_byte_idx,
    output logic                             o_word_done
);

    localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0]           r_idx;
    logic [BYTES_PER_WORD*8-1:0] r_word;

    // Lane register and byte index; clearing discards any partial word.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            r_word[{r_idx, 3'b000} +: 8] <= i_byte;
            r_idx                        <= r_idx + 1'b1;
        end
    end

    assign o_word      = r_word;
    assign o_byte_idx  = r_idx;
    assign o_word_done = i_accept && (r_idx == c_last_lane);

endmodule : byte_packer
`default_nettype wire

// File: rtl/ram_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_load_arbiter
// Description : Shares RAM port B between the CPU data path and the UART
//               program loader. The CPU owns the port combinationally in
//               normal mode; while prog_en is held, loader bytes are packed
//               into words and written to consecutive addresses from 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_load_arbiter
    import ram_load_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ram_load_arbiter_if.slave  bus
);

    if (DATA_W != BYTES_PER_WORD * 8) begin : g_bad_data_w
        $error("ram_load_arbiter: DATA_W must be %0d", BYTES_PER_WORD * 8);
    end

    localparam logic [ADDR_W:0] c_wc_max = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_load_addr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_frag_err;
    logic              r_mem_we;

    logic              w_accept;
    logic              w_clear;
    logic              w_word_done;
    logic              w_enter;
    logic              w_frag_set;
    logic [LANE_W-1:0] w_byte_idx;
    logic [DATA_W-1:0] w_word;

    // The packer only holds state while collecting; elsewhere it is cleared.
    assign w_accept = bus.ld_valid && (r_state == ST_COLLECT);
    assign w_clear  = (r_state != ST_COLLECT);

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_accept    (w_accept),
        .i_byte      (bus.ld_byte),
        .o_word      (w_word),
        .o_byte_idx  (w_byte_idx),
        .o_word_done (w_word_done)
    );

    // Next-state logic. A completed word always wins over prog_en falling,
    // so the last full word is written before draining.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_frag_set  = 1'b0;
        case (r_state)
            ST_CPU: begin
                if (bus.prog_en) begin
                    w_state_nxt = ST_COLLECT;
                    w_enter     = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (w_word_done) begin
                    w_state_nxt = ST_WRITE;
                end else if (!bus.prog_en) begin
                    w_state_nxt = ST_DRAIN;
                    // A byte accepted on this last cycle is also a fragment.
                    w_frag_set  = (w_byte_idx != '0) || w_accept;
                end
            end
            ST_WRITE: begin
                w_state_nxt = bus.prog_en ? ST_COLLECT : ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_nxt = ST_CPU;
            end
            default: begin
                w_state_nxt = ST_CPU;
            end
        endcase
    end

    // State register and the registered loader write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_CPU;
            r_mem_we <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_we <= (w_state_nxt == ST_WRITE);
        end
    end

    // Load address, word counter and sticky fragment flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_addr  <= '0;
            r_word_count <= '0;
            r_frag_err   <= 1'b0;
        end else if (w_enter) begin
            r_load_addr  <= '0;
            r_word_count <= '0;
            r_frag_err   <= 1'b0;
        end else begin
            if (r_state == ST_WRITE) begin
                r_load_addr <= r_load_addr + 1'b1;
                if (r_word_count != c_wc_max) begin
                    r_word_count <= r_word_count + 1'b1;
                end
            end
            if (w_frag_set) begin
                r_frag_err <= 1'b1;
            end
        end
    end

    // Port-B mux: CPU passthrough in normal mode, loader registers otherwise.
    always_comb begin
        bus.cpu_gnt   = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.mem_addr  = r_load_addr;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = w_word;
        case (r_state)
            ST_CPU: begin
                bus.cpu_gnt   = bus.cpu_req;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_we    = bus.cpu_req && bus.cpu_we;
                bus.mem_wdata = bus.cpu_wdata;
            end
            ST_COLLECT: begin
                bus.ld_ready  = 1'b1;
            end
            ST_WRITE: begin
                bus.mem_we    = r_mem_we;
            end
            default: begin
                bus.mem_we    = 1'b0;
            end
        endcase
    end

    assign bus.loading    = (r_state != ST_CPU);
    assign bus.word_count = r_word_count;
    assign bus.frag_err   = r_frag_err;

endmodule : ram_load_arbiter
`default_nettype wire

// File: tb/tb_ram_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_load_arbiter
// Description : Scoreboard bench for ram_load_arbiter. Two instances share
//               one stimulus stream: ADDR_W=12 and ADDR_W=2 (address wrap
//               and word_count saturation). Expected RAM writes are queued
//               by the stimulus and popped by a monitor on every mem_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_load_arbiter;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_en;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ld_valid;
    logic [7:0]  ld_byte;

    int  n_pass  = 0;
    int  n_total = 0;
    wr_t exp_a[$];
    wr_t exp_b[$];
    wr_t ea;
    wr_t eb;

    ram_load_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus_a ();
    ram_load_arbiter_if #(.ADDR_W(2),  .DATA_W(32)) bus_b ();

    assign bus_a.prog_en   = prog_en;
    assign bus_a.cpu_req   = cpu_req;
    assign bus_a.cpu_we    = cpu_we;
    assign bus_a.cpu_addr  = cpu_addr;
    assign bus_a.cpu_wdata = cpu_wdata;
    assign bus_a.ld_valid  = ld_valid;
    assign bus_a.ld_byte   = ld_byte;

    assign bus_b.prog_en   = prog_en;
    assign bus_b.cpu_req   = cpu_req;
    assign bus_b.cpu_we    = cpu_we;
    assign bus_b.cpu_addr  = cpu_addr[1:0];
    assign bus_b.cpu_wdata = cpu_wdata;
    assign bus_b.ld_valid  = ld_valid;
    assign bus_b.ld_byte   = ld_byte;

    ram_load_arbiter #(.ADDR_W(12), .DATA_W(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ram_load_arbiter #(.ADDR_W(2), .DATA_W(32)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
        exp_a.push_back('{addr: a, data: d});
        exp_b.push_back('{addr: {10'b0, a[1:0]}, data: d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        ld_byte  = b;
        ld_valid = 1'b1;
        for (int t = 0; t < 16 && !done; t++) begin
            @(negedge clk);
            if (bus_a.ld_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        ld_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL ld_accept_timeout: ld_ready stayed 0 for 16 cycles, expected 1");
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Write monitor: every RAM write must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.mem_we) begin
                if (exp_a.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write_a: addr %0h data %0h, expected no write",
                             bus_a.mem_addr, bus_a.mem_wdata);
                end else begin
                    ea = exp_a.pop_front();
                    chk("wr_addr_a", 64'(bus_a.mem_addr), 64'(ea.addr));
                    chk("wr_data_a", 64'(bus_a.mem_wdata), 64'(ea.data));
                    if (bus_a.loading) begin
                        chk("wr_ld_ready_a", 64'(bus_a.ld_ready), 64'd0);
                        chk("wr_cpu_gnt_a", 64'(bus_a.cpu_gnt), 64'd0);
                    end
                end
            end
            if (bus_b.mem_we) begin
                if (exp_b.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write_b: addr %0h data %0h, expected no write",
                             bus_b.mem_addr, bus_b.mem_wdata);
                end else begin
                    eb = exp_b.pop_front();
                    chk("wr_addr_b", 64'(bus_b.mem_addr), 64'(eb.addr));
                    chk("wr_data_b", 64'(bus_b.mem_wdata), 64'(eb.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; prog_en = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; ld_valid = 1'b0; ld_byte = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_loading",    64'(bus_a.loading),    64'd0);
        chk("rst_word_count", 64'(bus_a.word_count), 64'd0);
        chk("rst_frag_err",   64'(bus_a.frag_err),   64'd0);
        chk("rst_ld_ready",   64'(bus_a.ld_ready),   64'd0);
        chk("rst_cpu_gnt",    64'(bus_a.cpu_gnt),    64'd0);
        chk("rst_mem_we",     64'(bus_a.mem_we),     64'd0);

        // CPU write passthrough, same cycle.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'hDEADBEEF;
        push_wr(12'h010, 32'hDEADBEEF);
        @(negedge clk);
        chk("cpu_gnt",      64'(bus_a.cpu_gnt),  64'd1);
        chk("cpu_ld_ready", 64'(bus_a.ld_ready), 64'd0);
        chk("cpu_mem_we",   64'(bus_a.mem_we),   64'd1);

        // CPU read: granted, no write.
        tick();
        cpu_we = 1'b0; cpu_addr = 12'h0A5;
        @(negedge clk);
        chk("cpu_rd_gnt",  64'(bus_a.cpu_gnt),  64'd1);
        chk("cpu_rd_addr", 64'(bus_a.mem_addr), 64'h0A5);

        // prog_en rises with a CPU write: CPU keeps this cycle only.
        tick();
        prog_en = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 32'h11111111;
        push_wr(12'h020, 32'h11111111);
        @(negedge clk);
        chk("rise_cpu_gnt", 64'(bus_a.cpu_gnt), 64'd1);
        chk("rise_loading", 64'(bus_a.loading), 64'd0);
        tick();
        @(negedge clk);
        chk("coll_cpu_gnt",  64'(bus_a.cpu_gnt),  64'd0);
        chk("coll_loading",  64'(bus_a.loading),  64'd1);
        chk("coll_ld_ready", 64'(bus_a.ld_ready), 64'd1);
        chk("coll_mem_we",   64'(bus_a.mem_we),   64'd0);
        tick();
        cpu_we = 1'b0;

        // Load two words.
        push_wr(12'h000, 32'h00000013);
        push_wr(12'h001, 32'h00000008);
        send_word(32'h00000013);
        send_word(32'h00000008);
        @(negedge clk);
        chk("two_write_ld_ready", 64'(bus_a.ld_ready), 64'd0);
        chk("two_write_cpu_gnt",  64'(bus_a.cpu_gnt),  64'd0);
        tick();
        prog_en = 1'b0;
        @(negedge clk);
        chk("two_word_count", 64'(bus_a.word_count), 64'd2);
        tick();
        @(negedge clk);
        chk("two_drain_loading", 64'(bus_a.loading), 64'd1);
        chk("two_drain_cpu_gnt", 64'(bus_a.cpu_gnt), 64'd0);
        chk("two_drain_mem_we",  64'(bus_a.mem_we),  64'd0);
        tick();
        @(negedge clk);
        chk("two_end_loading",  64'(bus_a.loading),    64'd0);
        chk("two_end_cpu_gnt",  64'(bus_a.cpu_gnt),    64'd1);
        chk("two_end_frag_err", 64'(bus_a.frag_err),   64'd0);
        chk("two_end_wc",       64'(bus_a.word_count), 64'd2);

        // Partial word: 6 bytes, exactly one write, fragment flagged.
        tick();
        prog_en = 1'b1;
        tick();
        push_wr(12'h000, 32'h44332211);
        send_word(32'h44332211);
        send_byte(8'h55);
        send_byte(8'h66);
        prog_en = 1'b0;
        @(negedge clk);
        chk("frag_collect_loading", 64'(bus_a.loading), 64'd1);
        tick();
        @(negedge clk);
        chk("frag_drain_frag_err", 64'(bus_a.frag_err), 64'd1);
        chk("frag_drain_cpu_gnt",  64'(bus_a.cpu_gnt),  64'd0);
        chk("frag_drain_loading",  64'(bus_a.loading),  64'd1);
        tick();
        @(negedge clk);
        chk("frag_end_cpu_gnt",  64'(bus_a.cpu_gnt),    64'd1);
        chk("frag_end_loading",  64'(bus_a.loading),    64'd0);
        chk("frag_end_wc",       64'(bus_a.word_count), 64'd1);
        chk("frag_end_frag_err", 64'(bus_a.frag_err),   64'd1);

        // Five words: ADDR_W=2 instance wraps to 0 and saturates at 4.
        tick();
        prog_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push_wr(12'(i), 32'hA5000000 | i);
        for (int i = 0; i < 5; i++) send_word(32'hA5000000 | i);
        tick();
        prog_en = 1'b0;
        @(negedge clk);
        chk("bnd_wc_a",       64'(bus_a.word_count), 64'd5);
        chk("bnd_wc_b",       64'(bus_b.word_count), 64'd4);
        chk("bnd_frag_clear", 64'(bus_a.frag_err),   64'd0);
        tick();
        tick();
        @(negedge clk);
        chk("bnd_end_loading", 64'(bus_a.loading), 64'd0);

        // prog_en falls with the 4th byte: word still written, then DRAIN.
        tick();
        prog_en = 1'b1;
        tick();
        push_wr(12'h000, 32'h04030201);
        push_wr(12'h001, 32'h0D0C0B0A);
        send_word(32'h04030201);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        ld_byte = 8'h0D; ld_valid = 1'b1; prog_en = 1'b0;
        @(negedge clk);
        chk("fall_ld_ready", 64'(bus_a.ld_ready), 64'd1);
        tick();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("fall_write_we",      64'(bus_a.mem_we),  64'd1);
        chk("fall_write_loading", 64'(bus_a.loading), 64'd1);
        tick();
        @(negedge clk);
        chk("fall_drain_we",      64'(bus_a.mem_we),   64'd0);
        chk("fall_drain_loading", 64'(bus_a.loading),  64'd1);
        chk("fall_drain_frag",    64'(bus_a.frag_err), 64'd0);
        tick();
        @(negedge clk);
        chk("fall_end_loading", 64'(bus_a.loading),    64'd0);
        chk("fall_end_wc",      64'(bus_a.word_count), 64'd2);

        // Reset after two bytes of a new load.
        tick();
        prog_en = 1'b1;
        tick();
        send_byte(8'h77);
        send_byte(8'h88);
        rst = 1'b1; prog_en = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_loading",  64'(bus_a.loading),    64'd0);
        chk("mid_rst_frag_err", 64'(bus_a.frag_err),   64'd0);
        chk("mid_rst_wc",       64'(bus_a.word_count), 64'd0);
        chk("mid_rst_ld_ready", 64'(bus_a.ld_ready),   64'd0);
        chk("mid_rst_cpu_gnt",  64'(bus_a.cpu_gnt),    64'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("mid_rst_mem_we", 64'(bus_a.mem_we), 64'd0);

        chk("queue_a_empty", 64'(exp_a.size()), 64'd0);
        chk("queue_b_empty", 64'(exp_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ram_load_arbiter
`default_nettype wire
